// File: rtl/mtr_duty_ovr_ctrl.sv
// Motor duty register with over-current shutdown.
// Define OVR_I_RETRY_EN to add a timed cooldown that retries automatically.
module mtr_duty_ovr_ctrl #(
  parameter int unsigned OVR_PERIODS  = 3,
  parameter int unsigned COOL_PERIODS = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [11:0] spd,
  input  logic               OVR_I,
  input  logic               PWM_synch,
  input  logic               ovr_I_blank,
  input  logic               clr_shtdwn,
  output logic [10:0]        duty,
  output logic               shtdwn,
  output logic               ovr_evt
);

  localparam int unsigned DUTY_W = 11;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TGT_W  = 13;
  localparam logic [DUTY_W-1:0] DUTY_ZERO = 11'h400;
  localparam logic [DUTY_W-1:0] DUTY_MAX  = 11'h7FF;

  if (OVR_PERIODS < 1 || OVR_PERIODS > 15) begin : g_bad_ovr
    $error("OVR_PERIODS out of range 1..15");
  end
  if (COOL_PERIODS < 1 || COOL_PERIODS > 255) begin : g_bad_cool
    $error("COOL_PERIODS out of range 1..255");
  end

`ifdef OVR_I_RETRY_EN
  localparam int unsigned COOL_W = 8;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_SHUT = 2'd1, ST_COOL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_SHUT = 2'd1} state_t;
`endif

  state_t state, state_nx;

  logic             flag, flag_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [DUTY_W-1:0] duty_nx;
  logic             shtdwn_nx;
  logic             ovr_evt_nx;

  // Target duty: sign-extended speed offset to mid-scale, clamped to the duty range
  logic signed [TGT_W-1:0] tgt_sum;
  logic [DUTY_W-1:0]       tgt;
  assign tgt_sum = {spd[11], spd} + 13'sd1024;
  always_comb begin
    tgt = tgt_sum[DUTY_W-1:0];
    if (tgt_sum[TGT_W-1])            tgt = '0;
    else if (tgt_sum > 13'sd2047)    tgt = DUTY_MAX;
  end

  logic                qual;
  logic                hit;
  logic [CNT_W:0]      cnt_inc;
  logic                trip;
  assign qual    = OVR_I & ~ovr_I_blank & (state == ST_RUN);
  assign hit     = flag | qual;
  assign cnt_inc = {1'b0, cnt} + 5'd1;
  assign trip    = (state == ST_RUN) & PWM_synch & hit & (cnt_inc == 5'(OVR_PERIODS));

`ifdef OVR_I_RETRY_EN
  logic [COOL_W-1:0] cool_cnt, cool_cnt_nx;
  logic [COOL_W:0]   cool_inc;
  logic              cool_done;
  assign cool_inc  = {1'b0, cool_cnt} + 9'd1;
  assign cool_done = (cool_inc == 9'(COOL_PERIODS));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN:  if (trip) state_nx = ST_SHUT;
      ST_SHUT: begin
        if (clr_shtdwn) state_nx = ST_RUN;
`ifdef OVR_I_RETRY_EN
        else if (PWM_synch) state_nx = ST_COOL;
`endif
      end
`ifdef OVR_I_RETRY_EN
      ST_COOL: if (clr_shtdwn || (PWM_synch && cool_done)) state_nx = ST_RUN;
`endif
      default: state_nx = ST_RUN;
    endcase
  end

  // Next values for the registered outputs and period bookkeeping
  always_comb begin
    duty_nx    = duty;
    shtdwn_nx  = shtdwn;
    ovr_evt_nx = qual;
    flag_nx    = flag;
    cnt_nx     = cnt;
`ifdef OVR_I_RETRY_EN
    cool_cnt_nx = cool_cnt;
`endif
    case (state)
      ST_RUN: begin
        flag_nx = hit;
        if (PWM_synch) begin
          flag_nx = 1'b0;
          if (trip) begin
            cnt_nx    = '0;
            duty_nx   = DUTY_ZERO;
            shtdwn_nx = 1'b1;
          end else begin
            cnt_nx  = hit ? cnt_inc[CNT_W-1:0] : '0;
            duty_nx = tgt;
          end
        end
      end
      ST_SHUT: begin
        flag_nx   = 1'b0;
        cnt_nx    = '0;
        duty_nx   = DUTY_ZERO;
        shtdwn_nx = ~clr_shtdwn;
`ifdef OVR_I_RETRY_EN
        cool_cnt_nx = '0;
`endif
      end
`ifdef OVR_I_RETRY_EN
      ST_COOL: begin
        flag_nx = 1'b0;
        cnt_nx  = '0;
        duty_nx = DUTY_ZERO;
        if (clr_shtdwn) begin
          shtdwn_nx   = 1'b0;
          cool_cnt_nx = '0;
        end else if (PWM_synch) begin
          if (cool_done) begin
            shtdwn_nx   = 1'b0;
            cool_cnt_nx = '0;
          end else begin
            cool_cnt_nx = cool_inc[COOL_W-1:0];
          end
        end
      end
`endif
      default: begin
        flag_nx   = 1'b0;
        cnt_nx    = '0;
        duty_nx   = DUTY_ZERO;
        shtdwn_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty    <= DUTY_ZERO;
      shtdwn  <= 1'b0;
      ovr_evt <= 1'b0;
      flag    <= 1'b0;
      cnt     <= '0;
`ifdef OVR_I_RETRY_EN
      cool_cnt <= '0;
`endif
    end else begin
      duty    <= duty_nx;
      shtdwn  <= shtdwn_nx;
      ovr_evt <= ovr_evt_nx;
      flag    <= flag_nx;
      cnt     <= cnt_nx;
`ifdef OVR_I_RETRY_EN
      cool_cnt <= cool_cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_mtr_duty_ovr_ctrl.sv
// Scoreboard bench for mtr_duty_ovr_ctrl: a period-level reference model predicts
// duty/shtdwn/ovr_evt after every edge; a monitor compares each cycle.
module tb_mtr_duty_ovr_ctrl;

  localparam int unsigned OVR_P  = 3;
  localparam int unsigned COOL_P = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [11:0] spd;
  logic               OVR_I;
  logic               PWM_synch;
  logic               ovr_I_blank;
  logic               clr_shtdwn;
  logic [10:0]        duty;
  logic               shtdwn;
  logic               ovr_evt;

  mtr_duty_ovr_ctrl #(.OVR_PERIODS(OVR_P), .COOL_PERIODS(COOL_P)) dut (
    .clk(clk), .rst_n(rst_n), .spd(spd), .OVR_I(OVR_I), .PWM_synch(PWM_synch),
    .ovr_I_blank(ovr_I_blank), .clr_shtdwn(clr_shtdwn),
    .duty(duty), .shtdwn(shtdwn), .ovr_evt(ovr_evt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] duty;
    logic        sh;
    logic        evt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: mode 0 = driving, 1 = latched off, 2 = cooling down
  int mode = 0, streak = 0, cool_n = 0, m_duty = 1024;
  bit hit = 0, m_sh = 0, m_evt = 0;
`ifdef OVR_I_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  function automatic int target(input logic signed [11:0] s);
    int v;
    v = int'(s) + 1024;
    if (v < 0) v = 0;
    if (v > 2047) v = 2047;
    return v;
  endfunction

  task automatic model_step();
    bit q;
    if (!rst_n) begin
      mode = 0; streak = 0; cool_n = 0; m_duty = 1024; hit = 0; m_sh = 0; m_evt = 0;
      return;
    end
    q = OVR_I && !ovr_I_blank && (mode == 0);
    m_evt = q;
    if (mode == 0) begin
      if (q) hit = 1;
      if (PWM_synch) begin
        streak = hit ? streak + 1 : 0;
        hit = 0;
        if (streak == int'(OVR_P)) begin
          mode = 1; m_sh = 1; m_duty = 1024; streak = 0;
        end else begin
          m_duty = target(spd);
        end
      end
    end else if (mode == 1) begin
      if (clr_shtdwn) begin
        mode = 0; m_sh = 0;
      end else if (RETRY && PWM_synch) begin
        mode = 2; cool_n = 0;
      end
    end else begin
      if (clr_shtdwn) begin
        mode = 0; m_sh = 0;
      end else if (PWM_synch) begin
        cool_n++;
        if (cool_n == int'(COOL_P)) begin
          mode = 0; m_sh = 0;
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic [11:0] s, input logic o,
                       input logic sy, input logic b, input logic c);
    exp_t e;
    @(negedge clk);
    rst_n = r; spd = s; OVR_I = o; PWM_synch = sy; ovr_I_blank = b; clr_shtdwn = c;
    model_step();
    e.duty = 11'(m_duty);
    e.sh   = m_sh;
    e.evt  = m_evt;
    exp_q.push_back(e);
  endtask

  // One PWM period: synch on the first cycle; ovr_at=-2 means OVR_I high throughout
  task automatic period(input int len, input logic [11:0] s_sync, input logic [11:0] s_mid,
                        input int ovr_at, input logic b);
    for (int i = 0; i < len; i++)
      drive(1'b1, (i == 0) ? s_sync : s_mid, (ovr_at == -2) || (i == ovr_at), i == 0, b, 1'b0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (duty !== e.duty) begin
        bad++;
        $display("FAIL duty t=%0t got=%h want=%h", $time, duty, e.duty);
      end
      total++;
      if (shtdwn !== e.sh) begin
        bad++;
        $display("FAIL shtdwn t=%0t got=%b want=%b", $time, shtdwn, e.sh);
      end
      total++;
      if (ovr_evt !== e.evt) begin
        bad++;
        $display("FAIL ovr_evt t=%0t got=%b want=%b", $time, ovr_evt, e.evt);
      end
    end
  end

  initial begin
    rst_n = 1'b0; spd = '0; OVR_I = 1'b0; PWM_synch = 1'b0; ovr_I_blank = 1'b0; clr_shtdwn = 1'b0;
    drive(1'b0, 12'h3A5, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clamp high, clamp low, mid value; mid-period spd changes must not leak through
    period(6, 12'h7FF, 12'h000, -1, 1'b0);
    period(6, 12'h800, 12'h7FF, -1, 1'b0);
    period(6, 12'h100, 12'h800, -1, 1'b0);

    // Blanked over-current never qualifies
    period(8, 12'h100, 12'h100, -2, 1'b1);
    period(8, 12'h0F0, 12'h0F0, -2, 1'b1);

    // Clean period breaks the streak, then three consecutive periods trip
    period(6, 12'h050, 12'h050, 2, 1'b0);
    period(6, 12'h050, 12'h050, 3, 1'b0);
    period(6, 12'h050, 12'h050, -1, 1'b0);
    period(6, 12'h050, 12'h050, 1, 1'b0);
    period(6, 12'h050, 12'h050, 4, 1'b0);
    period(6, 12'hF00, 12'hF00, 0, 1'b0);
    for (int k = 0; k < 10; k++) period(5, 12'h200, 12'h200, 2, 1'b0);
    drive(1'b1, 12'h200, 1'b0, 1'b0, 1'b0, 1'b1);
    period(5, 12'h200, 12'h200, -1, 1'b0);
    period(5, 12'h210, 12'h210, -1, 1'b0);

    // Clear request coincident with the tripping synch loses
    period(5, 12'h010, 12'h010, 2, 1'b0);
    period(5, 12'h010, 12'h010, 2, 1'b0);
    period(5, 12'h010, 12'h010, 2, 1'b0);
    drive(1'b1, 12'h010, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while latched off
    drive(1'b0, 12'h010, 1'b1, 1'b1, 1'b0, 1'b0);
    period(5, 12'h300, 12'h300, -1, 1'b0);

    // Randomized traffic
    for (int p = 0; p < 300; p++) begin
      int len;
      len = int'($urandom_range(3, 10));
      for (int i = 0; i < len; i++)
        drive(($urandom_range(0, 499) != 0), 12'($urandom), ($urandom_range(0, 5) == 0),
              (i == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mtr_duty_ovr_ctrl.md
MTR_DUTY_OVR_CTRL -- requirements
Module: mtr_duty_ovr_ctrl

Interface
REQ-001 The block SHALL have parameter OVR_PERIODS, default 3: consecutive PWM periods with an unblanked over-current event that trigger shutdown (range 1..15).
REQ-002 The block SHALL have parameter COOL_PERIODS, default 64: PWM periods spent in cooldown before auto-retry (range 1..255; used only with OVR_I_RETRY_EN).
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  system clock; every register updates on its rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 spd  input  12  signed requested motor drive (two's complement).
REQ-007 OVR_I  input  1  raw over-current comparator output, high = over-current.
REQ-008 PWM_synch  input  1  one-cycle pulse at the start of each PWM period, from the PWM generator.
REQ-009 ovr_I_blank  input  1  high = current sense invalid, from the PWM generator.
REQ-010 clr_shtdwn  input  1  one-cycle request to leave shutdown.
REQ-011 duty  output  11  unsigned duty to the PWM generator; 0x400 = zero torque.
REQ-012 shtdwn  output  1  high while drive is disabled for over-current.
REQ-013 ovr_evt  output  1  registered one-cycle pulse for each qualified over-current sample.

Function
REQ-014 The target duty SHALL be computed as spd sign-extended to 13 bits plus 0x400, clamped to 0x000 when negative and to 0x7FF when above 0x7FF.
REQ-015 The duty register SHALL load the target only on a cycle with PWM_synch=1 in state RUN, so duty is stable for a whole period; spd changes between pulses have no effect.
REQ-016 A sample SHALL be qualified when OVR_I=1, ovr_I_blank=0 and state=RUN; ovr_evt SHALL pulse on the edge after each qualified sample.
REQ-017 A per-period flag SHALL be set by any qualified sample; a qualified sample on the PWM_synch cycle counts toward the period being closed.
REQ-018 On each PWM_synch in RUN the block SHALL update a 4-bit consecutive-period counter: increment if the closing period's flag (including that cycle's sample) is set, else clear to 0; then clear the flag.
REQ-019 The FSM states SHALL be RUN, SHUT and, with OVR_I_RETRY_EN only, COOL.
REQ-020 RUN->SHUT SHALL occur on the PWM_synch edge at which the counter would reach OVR_PERIODS; on that same edge shtdwn SHALL go 1 and duty SHALL be forced to 0x400.
REQ-021 In SHUT or COOL, duty SHALL hold 0x400, shtdwn SHALL be 1, and the flag and counter SHALL hold 0.
REQ-022 SHUT/COOL->RUN on clr_shtdwn=1 SHALL clear shtdwn on the next edge; duty SHALL stay 0x400 until the next PWM_synch loads a target.
REQ-023 clr_shtdwn in RUN SHALL have no effect; clr_shtdwn on the same cycle as a shutdown-triggering PWM_synch SHALL lose, and shutdown SHALL be entered.

Reset
REQ-024 With rst_n=0 at a clock edge: state RUN, duty 0x400, shtdwn 0, ovr_evt 0, flag 0, counters 0.
REQ-025 Reset SHALL override all other inputs, including mid-shutdown and mid-cooldown.
REQ-026 No output SHALL change on rst_n without a clock edge.

Configuration
REQ-027 The macro OVR_I_RETRY_EN SHALL select auto-retry.
REQ-028 With OVR_I_RETRY_EN defined: SHUT SHALL go to COOL on the next PWM_synch; COOL SHALL count PWM_synch pulses and go to RUN on the COOL_PERIODS-th pulse, clearing shtdwn there; clr_shtdwn SHALL also exit COOL immediately.
REQ-029 Without OVR_I_RETRY_EN: COOL and its 8-bit counter SHALL not exist; SHUT SHALL be left only by clr_shtdwn or reset.

Verification
REQ-030 spd=0x7FF, then 0x800, then 0x100, each held across a PWM_synch -> duty = 0x7FF, 0x000, 0x500, each changing only on the synch edge.
REQ-031 OVR_I=1 with ovr_I_blank=1 for a full period -> no ovr_evt, counter 0, duty tracks spd.
REQ-032 One unblanked OVR_I pulse in each of 3 consecutive periods -> shtdwn=1 and duty=0x400 on the 3rd closing PWM_synch edge; with a clean period between the 2nd and 3rd pulses -> no shutdown.
REQ-033 Without the macro, in SHUT for 10 periods -> shtdwn stays 1; clr_shtdwn pulse -> shtdwn=0 next edge, and duty = target at the following PWM_synch.
REQ-034 With the macro and COOL_PERIODS=4 -> shtdwn clears on the 4th PWM_synch after COOL entry.
REQ-035 rst_n=0 for one edge during SHUT -> all outputs at reset values after that edge; clr_shtdwn coincident with the triggering synch -> shtdwn=1.
